// File: rtl/llnn_pkg.sv
// Shared types and sizing helpers for the LLNN batch sequencer.
package llnn_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, EMIT} state_t;

    // Number of stream words needed to cover the network input vector.
    function automatic int words_f(input int net_inputs, input int word_w);
        return (net_inputs + word_w - 1) / word_w;
    endfunction

    // Word index width; never zero, so a single-word sample still gets a bit.
    function automatic int idx_w_f(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int DEF_WORDS = words_f(400, 32);
    localparam int DEF_IDX_W = idx_w_f(DEF_WORDS);

endpackage

// File: rtl/llnn_input_packer.sv
// Packs LSW-first stream words into the registered network input vector.
module llnn_input_packer
    import llnn_pkg::*;
#(
    parameter int NET_INPUTS = 400,
    parameter int WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr,
    input  logic [WORD_W-1:0]     data,
    output logic                  last,
    output logic [NET_INPUTS-1:0] net_i
);

    localparam int WORDS  = words_f(NET_INPUTS, WORD_W);
    localparam int IDX_W  = idx_w_f(WORDS);
    localparam int LAST_LO = (WORDS - 1) * WORD_W;
    localparam int LAST_W  = NET_INPUTS - LAST_LO;

    logic [IDX_W-1:0] idx;

    assign last = (idx == IDX_W'(WORDS - 1));

    // Index sits at 0 outside LOAD, so every sample and every restart begins at word 0.
    always_ff @(posedge clk) begin
        if (rst || clear)
            idx <= '0;
        else if (wr)
            idx <= last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            net_i <= '0;
        end else if (wr) begin
            for (int k = 0; k < WORDS - 1; k++)
                if (idx == IDX_W'(k))
                    net_i[k*WORD_W +: WORD_W] <= data;
            // Final word only contributes its low LAST_W bits.
            if (last)
                net_i[LAST_LO +: LAST_W] <= data[LAST_W-1:0];
        end
    end

endmodule

// File: rtl/llnn_batch_sequencer.sv
// Streams a batch of samples through the combinational LLNN network, one result per sample.
module llnn_batch_sequencer
    import llnn_pkg::*;
#(
    parameter int NET_INPUTS    = 400,
    parameter int NET_OUTPUTS   = 4,
    parameter int WORD_W        = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [15:0]            batch_len,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            samples_done,
    input  logic [WORD_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [NET_OUTPUTS-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NET_INPUTS-1:0]  net_i,
    input  logic [NET_OUTPUTS-1:0] net_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [15:0]      len_q;
    logic [CNT_W-1:0] cnt;
    logic             start_go, word_wr, last_word, res_hs, last_sample;

    assign start_go    = start && !abort;
    assign word_wr     = (state == LOAD) && s_valid && !abort;
    assign res_hs      = (state == EMIT) && m_ready && !abort;
    assign last_sample = (samples_done + 16'd1) == len_q;

    llnn_input_packer #(
        .NET_INPUTS (NET_INPUTS),
        .WORD_W     (WORD_W)
    ) u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (state != LOAD),
        .wr    (word_wr),
        .data  (s_data),
        .last  (last_word),
        .net_i (net_i)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_go && batch_len != 16'd0) state_nxt = LOAD;
            LOAD:    if (abort) state_nxt = IDLE;
                     else if (word_wr && last_word) state_nxt = SETTLE;
            SETTLE:  if (abort) state_nxt = IDLE;
                     else if (cnt == '0) state_nxt = EMIT;
            EMIT:    if (abort) state_nxt = IDLE;
                     else if (res_hs) state_nxt = last_sample ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        s_ready = (state == LOAD);
        m_valid = (state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            cnt          <= '0;
            m_data       <= '0;
            samples_done <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start_go) begin
                if (batch_len != 16'd0) begin
                    len_q        <= batch_len;
                    samples_done <= '0;
                end else begin
                    done <= 1'b1;
                end
            end
            if (word_wr && last_word)
                cnt <= CNT_W'(SETTLE_CYCLES - 1);
            // net_i has been stable for SETTLE_CYCLES when the counter reaches 0.
            if (state == SETTLE && !abort) begin
                if (cnt == '0)
                    m_data <= net_o;
                else
                    cnt <= cnt - 1'b1;
            end
            if (res_hs) begin
                samples_done <= samples_done + 16'd1;
                if (last_sample)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_llnn_batch_sequencer.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them on result handshakes.
module tb_llnn_batch_sequencer;

    typedef logic [31:0] sample_t [13];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  batch_len = '0;
    logic         busy, done, s_ready, m_valid;
    logic [15:0]  samples_done;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic [3:0]   m_data;
    logic         m_ready = 1'b0;
    logic [399:0] net_i;
    logic [3:0]   net_o;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [3:0] net_model(input logic [399:0] v);
        return {^v[399:300], ^v[299:200], ^v[199:100], ^v[99:0]};
    endfunction

    // Bit-by-bit placement of the words; anything beyond bit 399 is dropped.
    function automatic logic [399:0] pack(input sample_t w);
        logic [399:0] v;
        v = '0;
        for (int k = 0; k < 13; k++)
            for (int b = 0; b < 32; b++)
                if (k * 32 + b < 400) v[k*32+b] = w[k][b];
        return v;
    endfunction

    assign net_o = net_model(net_i);

    llnn_batch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .batch_len    (batch_len),
        .busy         (busy),
        .done         (done),
        .samples_done (samples_done),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .net_i        (net_i),
        .net_o        (net_o)
    );

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1'b1, 1'b0);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                check("result", m_data, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start = 1'b1;
        batch_len = len;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        bit got;
        s_valid = 1'b0;
        repeat ($urandom_range(0, gmax)) step();
        s_data = w;
        s_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) check("word_timeout", 1'b0, 1'b1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_sample(input sample_t w, input int gmax);
        for (int k = 0; k < 13; k++) send_word(w[k], gmax);
        sb.push_back(net_model(pack(w)));
    endtask

    task automatic rand_sample(output sample_t w);
        for (int k = 0; k < 13; k++) w[k] = $urandom;
    endtask

    task automatic wait_mvalid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) check("mvalid_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        sample_t w;
        int d0;

        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_net_i", net_i, '0);
        check("rst_samples_done", samples_done, 16'd0);
        step();

        // Single sample with truncated last word, then result backpressure.
        for (int k = 0; k < 13; k++) w[k] = '0;
        w[0] = 32'h1;
        w[12] = 32'hFFFF_0000;
        do_start(16'd1);
        @(negedge clk);
        check("s_ready_after_start", s_ready, 1'b1);
        check("busy_after_start", busy, 1'b1);
        step();
        send_sample(w, 0);
        @(negedge clk);
        check("mvalid_T1", m_valid, 1'b0);
        step();
        @(negedge clk);
        check("mvalid_T2", m_valid, 1'b0);
        step();
        @(negedge clk);
        check("mvalid_T3", m_valid, 1'b1);
        check("m_data_trunc", m_data, 4'b0001);
        check("net_i_trunc", net_i, 400'h1);
        step();
        s_valid = 1'b1;
        s_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_m_data", m_data, 4'b0001);
            check("bp_s_ready", s_ready, 1'b0);
            check("bp_net_i", net_i, pack(w));
            step();
        end
        d0 = done_cnt;
        m_ready = 1'b1;
        @(negedge clk);
        step();
        m_ready = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("single_done", done, 1'b1);
        check("single_busy", busy, 1'b0);
        check("single_samples_done", samples_done, 16'd1);
        check("single_s_ready", s_ready, 1'b0);
        step();

        // Zero-length batch.
        d0 = done_cnt;
        start = 1'b1;
        batch_len = 16'd0;
        @(negedge clk);
        check("zero_busy_t", busy, 1'b0);
        check("zero_done_t", done, 1'b0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_s_ready", s_ready, 1'b0);
        step();
        @(negedge clk);
        check("zero_busy2", busy, 1'b0);
        check("zero_done_once", done_cnt - d0, 1);
        step();

        // Multi-sample with random word gaps and random result readiness.
        d0 = done_cnt;
        do_start(16'd3);
        fork
            begin
                sample_t r;
                for (int s = 0; s < 3; s++) begin
                    rand_sample(r);
                    send_sample(r, 3);
                end
            end
            begin
                for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
                    step();
                    m_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_ready = 1'b0;
        step();
        @(negedge clk);
        check("multi_done_count", done_cnt - d0, 1);
        check("multi_samples_done", samples_done, 16'd3);
        check("multi_sb_empty", sb.size(), 0);
        check("multi_busy", busy, 1'b0);
        step();

        // Abort mid-sample 2 of 4, with a stale start issued while in EMIT.
        d0 = done_cnt;
        do_start(16'd4);
        rand_sample(w);
        send_sample(w, 1);
        wait_mvalid();
        step();
        start = 1'b1;
        batch_len = 16'd1;
        step();
        start = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        step();
        m_ready = 1'b0;
        @(negedge clk);
        check("stale_start_no_done", done, 1'b0);
        check("stale_start_s_ready", s_ready, 1'b1);
        check("stale_start_count", samples_done, 16'd1);
        step();
        rand_sample(w);
        for (int k = 0; k < 5; k++) send_word(w[k], 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_s_ready", s_ready, 1'b0);
        check("abort_samples_done", samples_done, 16'd1);
        repeat (3) step();
        check("abort_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        do_start(16'd1);
        rand_sample(w);
        send_word(w[0], 0);
        @(negedge clk);
        check("restart_word0", net_i[31:0], w[0]);
        step();
        for (int k = 1; k < 13; k++) send_word(w[k], 1);
        sb.push_back(net_model(pack(w)));
        m_ready = 1'b1;
        for (int i = 0; i < 50 && done_cnt == d0; i++) step();
        m_ready = 1'b0;
        check("restart_done", done_cnt - d0, 1);
        check("restart_net_i", net_i, pack(w));
        check("restart_samples_done", samples_done, 16'd1);

        // Reset while a result is pending.
        do_start(16'd2);
        rand_sample(w);
        send_sample(w, 0);
        wait_mvalid();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mrst_busy", busy, 1'b0);
        check("mrst_m_valid", m_valid, 1'b0);
        check("mrst_m_data", m_data, 4'b0);
        check("mrst_s_ready", s_ready, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_samples_done", samples_done, 16'd0);
        check("mrst_net_i", net_i, '0);
        step();

        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
